// File: rtl/lib_switchblock_pkg.sv
// ----------------------------------------------------------------------------
// lib_switchblock_pkg
//
// Purpose:
//   Constants shared by the multi-bit quantizer and the downstream DEM
//   switch-block. Both sides must agree on the level-code width and on the
//   weight of one level, so these values are defined only here.
//
// Contents:
//   INPUT_WIDTH   width of the input sample, the NTF feedback and the error
//   OUTPUT_WIDTH  width of the quantized level code
//   QUANT_SHIFT   log2 of the quantizer step size
//   QUANT_STEP    weight of one output level, in input LSBs
//   QMAX          highest level code; larger results saturate to this value
// ----------------------------------------------------------------------------
package lib_switchblock_pkg;

  localparam int INPUT_WIDTH  = 16;
  localparam int OUTPUT_WIDTH = 3;
  localparam int QUANT_SHIFT  = INPUT_WIDTH - OUTPUT_WIDTH;
  localparam int QUANT_STEP   = 2 ** QUANT_SHIFT;
  localparam int QMAX         = 2 ** OUTPUT_WIDTH - 1;

endpackage : lib_switchblock_pkg

// File: rtl/quantizer.sv
// ----------------------------------------------------------------------------
// quantizer
//
// Purpose:
//   Multi-bit quantizer stage of the delta-sigma / DEM-DAC path. Each cycle
//   it adds the noise-shaping feedback to the input sample, rounds the sum
//   (round half up) to a level code, saturates that code at QMAX and reports
//   the quantization error (sum minus reconstructed level), clamped to the
//   signed INPUT_WIDTH range, for the NTF loop filter. One cycle of latency;
//   both outputs update together on every clock.
//
// Ports:
//   clk_i            in   1             clock, rising edge
//   rst_i            in   1             synchronous, active-high reset
//   x_in_i           in   INPUT_WIDTH   input sample, unsigned
//   ntf_in_i         in   INPUT_WIDTH   NTF feedback, unsigned
//   quantized_out_o  out  OUTPUT_WIDTH  level code, unsigned, registered
//   quant_error_o    out  INPUT_WIDTH   quantization error, signed, registered
// ----------------------------------------------------------------------------
module quantizer
  import lib_switchblock_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [INPUT_WIDTH-1:0]         x_in_i,
  input  logic [INPUT_WIDTH-1:0]         ntf_in_i,
  output logic [OUTPUT_WIDTH-1:0]        quantized_out_o,
  output logic signed [INPUT_WIDTH-1:0]  quant_error_o
);

  // Sum carries one extra bit; the rounding bias needs one more on top.
  localparam int SUM_W  = INPUT_WIDTH + 1;
  localparam int BIAS_W = INPUT_WIDTH + 2;
  // Unsaturated level code: enough bits for (max sum + half step) >> shift.
  localparam int QRAW_W = BIAS_W - QUANT_SHIFT;
  // Error working width: sum and reconstructed level both fit, signed.
  localparam int ERR_W  = INPUT_WIDTH + 3;

  localparam logic signed [ERR_W-1:0] ERR_POS_LIM = ERR_W'(2 ** (INPUT_WIDTH - 1) - 1);
  localparam logic signed [ERR_W-1:0] ERR_NEG_LIM = -ERR_POS_LIM - ERR_W'(1);

  // Round half up: add half a step, then drop the fractional bits.
  function automatic logic [QRAW_W-1:0] round_half_up(input logic [SUM_W-1:0] s);
    logic [BIAS_W-1:0] biased;
    biased = {1'b0, s} + BIAS_W'(QUANT_STEP / 2);
    return biased[BIAS_W-1:QUANT_SHIFT];
  endfunction

  // Saturate the level code at QMAX.
  function automatic logic [OUTPUT_WIDTH-1:0] sat_level(input logic [QRAW_W-1:0] r);
    if (r > QRAW_W'(QMAX)) begin
      return OUTPUT_WIDTH'(QMAX);
    end
    return r[OUTPUT_WIDTH-1:0];
  endfunction

  // Clamp the wide error into the signed INPUT_WIDTH range. Only the positive
  // side is reachable (saturated large sums), the negative clamp is a guard.
  function automatic logic signed [INPUT_WIDTH-1:0] sat_error(input logic signed [ERR_W-1:0] d);
    logic signed [ERR_W-1:0] c;
    if (d > ERR_POS_LIM) begin
      c = ERR_POS_LIM;
    end else if (d < ERR_NEG_LIM) begin
      c = ERR_NEG_LIM;
    end else begin
      c = d;
    end
    return c[INPUT_WIDTH-1:0];
  endfunction

  // ---- stage p0: combinational sum, round, saturate, error ----
  logic [SUM_W-1:0]                sum_p0;
  logic [QRAW_W-1:0]               qraw_p0;
  logic [OUTPUT_WIDTH-1:0]         q_p0;
  logic signed [ERR_W-1:0]         sum_s_p0;
  logic signed [ERR_W-1:0]         level_s_p0;
  logic signed [ERR_W-1:0]         diff_p0;
  logic signed [INPUT_WIDTH-1:0]   err_p0;

  always_comb begin
    sum_p0     = {1'b0, x_in_i} + {1'b0, ntf_in_i};
    qraw_p0    = round_half_up(sum_p0);
    q_p0       = sat_level(qraw_p0);
    sum_s_p0   = signed'(ERR_W'(sum_p0));
    // Reconstructed level q*QUANT_STEP, built by placing q above the step bits.
    level_s_p0 = signed'(ERR_W'({q_p0, {QUANT_SHIFT{1'b0}}}));
    diff_p0    = sum_s_p0 - level_s_p0;
    err_p0     = sat_error(diff_p0);
  end

  // ---- stage p1: output register ----
  logic [OUTPUT_WIDTH-1:0]         q_p1;
  logic signed [INPUT_WIDTH-1:0]   err_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_p1   <= '0;
      err_p1 <= '0;
    end else begin
      q_p1   <= q_p0;
      err_p1 <= err_p0;
    end
  end

  assign quantized_out_o = q_p1;
  assign quant_error_o   = err_p1;

endmodule : quantizer

// File: tb/tb_quantizer.sv
// ----------------------------------------------------------------------------
// tb_quantizer
//
// Self-checking bench for quantizer. Inputs are driven on the falling edge
// and outputs are sampled 1 ns after the following rising edge. Expected
// values come from a plain-integer reference model of the quantizer rules.
// ----------------------------------------------------------------------------
module tb_quantizer;
  import lib_switchblock_pkg::*;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic [INPUT_WIDTH-1:0]        x_in_i;
  logic [INPUT_WIDTH-1:0]        ntf_in_i;
  logic [OUTPUT_WIDTH-1:0]       quantized_out_o;
  logic signed [INPUT_WIDTH-1:0] quant_error_o;

  int errors = 0;
  int checks = 0;

  quantizer dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .x_in_i          (x_in_i),
    .ntf_in_i        (ntf_in_i),
    .quantized_out_o (quantized_out_o),
    .quant_error_o   (quant_error_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model in plain integer arithmetic.
  function automatic void model(input int x, input int ntf, output int q, output int e);
    int s;
    int qr;
    s  = x + ntf;
    qr = (s + QUANT_STEP / 2) / QUANT_STEP;
    q  = (qr > QMAX) ? QMAX : qr;
    e  = s - q * QUANT_STEP;
    if (e > 32767)  e = 32767;
    if (e < -32768) e = -32768;
  endfunction

  // Drive one cycle: set inputs at the falling edge, wait for the rising
  // edge that samples them, then step 1 ns past it.
  task automatic drive(input logic r, input int x, input int ntf);
    @(negedge clk_i);
    rst_i    = r;
    x_in_i   = INPUT_WIDTH'(x);
    ntf_in_i = INPUT_WIDTH'(ntf);
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 65535, 65535);
    checks++;
    if (quantized_out_o !== '0) begin
      errors++;
      $display("FAIL reset_q: got %0d expected 0", quantized_out_o);
    end
    checks++;
    if (quant_error_o !== '0) begin
      errors++;
      $display("FAIL reset_err: got %0d expected 0", quant_error_o);
    end
  endtask

  task automatic test_directed();
    int xs [7]   = '{0, 32768, 65535, 16384, 8191, 65535, 20000};
    int ns [7]   = '{0, 1024,  8192,  4096,  512,  65535, 0};
    int eq [7]   = '{0, 4,     7,     3,     1,    7,     2};
    int ee [7]   = '{0, 1024,  16383, -4096, 511,  32767, 3616};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, xs[i], ns[i]);
      checks++;
      if (quantized_out_o !== OUTPUT_WIDTH'(eq[i])) begin
        errors++;
        $display("FAIL directed_q[%0d] x=%0d ntf=%0d: got %0d expected %0d",
                 i, xs[i], ns[i], quantized_out_o, eq[i]);
      end
      checks++;
      if (quant_error_o !== INPUT_WIDTH'(ee[i])) begin
        errors++;
        $display("FAIL directed_err[%0d] x=%0d ntf=%0d: got %0d expected %0d",
                 i, xs[i], ns[i], quant_error_o, ee[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 40000, 3000);
    drive(1'b1, 40000, 3000);
    checks++;
    if (quantized_out_o !== '0 || quant_error_o !== '0) begin
      errors++;
      $display("FAIL mid_reset: got q=%0d err=%0d expected q=0 err=0",
               quantized_out_o, quant_error_o);
    end
    drive(1'b0, 12345, 256);
    checks++;
    if (quantized_out_o !== 3'd2 || quant_error_o !== -16'sd3783) begin
      errors++;
      $display("FAIL after_reset: got q=%0d err=%0d expected q=2 err=-3783",
               quantized_out_o, quant_error_o);
    end
  endtask

  // Back-to-back random inputs; each sample is checked against the inputs of
  // the edge just taken, which also proves one-cycle alignment of both outputs.
  task automatic test_random();
    int x, ntf, q, e;
    for (int i = 0; i < 400; i++) begin
      x   = int'($urandom_range(0, 65535));
      ntf = (i % 4 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 16383));
      drive(1'b0, x, ntf);
      model(x, ntf, q, e);
      checks++;
      if (quantized_out_o !== OUTPUT_WIDTH'(q) || quant_error_o !== INPUT_WIDTH'(e)) begin
        errors++;
        $display("FAIL random[%0d] x=%0d ntf=%0d: got q=%0d err=%0d expected q=%0d err=%0d",
                 i, x, ntf, quantized_out_o, quant_error_o, q, e);
      end
      if (quantized_out_o < 3'(QMAX)) begin
        checks++;
        if (quant_error_o > 16'sd4096 || quant_error_o < -16'sd4096) begin
          errors++;
          $display("FAIL err_bound[%0d]: got err=%0d with q=%0d, required |err|<=4096",
                   i, quant_error_o, quantized_out_o);
        end
      end
    end
  endtask

  initial begin
    rst_i    = 1'b1;
    x_in_i   = '0;
    ntf_in_i = '0;
    test_reset();
    test_directed();
    test_mid_reset();
    test_random();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_quantizer
